// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider family.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_restore_core_if.sv
// Handshake and data bundle between a requester and the restoring divider core.
interface div_restore_core_if import div_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic             i_start;
  logic [WIDTH-1:0] i_dividend;
  logic             o_ld_b;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_div_by_zero;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_ld_b, o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_ld_b, o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
  );

endinterface

// File: rtl/div_restore_step.sv
// One shift/subtract/restore step of an unsigned restoring divider (combinational).
module div_restore_step import div_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);

  logic [2*WIDTH:0] w_shift;
  logic [WIDTH:0]   w_a_sh;
  logic [WIDTH:0]   w_t;

  assign w_shift = {i_a, i_q} << 1;
  assign w_a_sh  = w_shift[2*WIDTH:WIDTH];
  assign w_t     = w_a_sh - {1'b0, i_divisor};

  // A set MSB on the trial difference means it borrowed: keep the shifted value.
  always_comb begin
    o_a = w_t[WIDTH] ? w_a_sh : w_t;
    o_q = w_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~w_t[WIDTH]};
  end

endmodule

// File: rtl/div_restore_core.sv
// Iterative restoring divider wrapped around an external divisor register loaded via o_ld_b.
module div_restore_core import div_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic               i_clk,
  input logic               i_rst,
  div_restore_core_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_e       r_state, w_state_next;
  logic [WIDTH:0]   r_a, w_a_next, w_step_a;
  logic [WIDTH-1:0] r_q, w_q_next, w_step_q;
  logic [WIDTH-1:0] r_quotient, w_quotient_next;
  logic [WIDTH-1:0] r_remainder, w_remainder_next;
  logic [CW-1:0]    r_count, w_count_next;
  logic             r_dbz, w_dbz_next;
  logic             r_dbz_pend, w_dbz_pend_next;
  logic             w_ready, w_accept;

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a       (r_a),
    .i_q       (r_q),
    .i_divisor (bus.i_divisor),
    .o_a       (w_step_a),
    .o_q       (w_step_q)
  );

  assign w_ready  = (r_state == IDLE) || (r_state == DONE);
  assign w_accept = w_ready && bus.i_start;

  assign bus.o_ld_b        = w_accept && !i_rst;
  assign bus.o_busy        = (r_state == LOAD) || (r_state == ITER);
  assign bus.o_done        = (r_state == DONE);
  assign bus.o_quotient    = r_quotient;
  assign bus.o_remainder   = r_remainder;
  assign bus.o_div_by_zero = r_dbz;

  always_comb begin
    w_state_next     = r_state;
    w_a_next         = r_a;
    w_q_next         = r_q;
    w_count_next     = r_count;
    w_quotient_next  = r_quotient;
    w_remainder_next = r_remainder;
    w_dbz_next       = r_dbz;
    w_dbz_pend_next  = r_dbz_pend;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_q_next     = bus.i_dividend;
          w_state_next = LOAD;
        end else begin
          w_state_next = IDLE;
        end
      end
      LOAD: begin
        w_a_next        = '0;
        w_count_next    = CW'(WIDTH - 1);
        // The divisor register has captured its value by now.
        w_dbz_pend_next = (bus.i_divisor == '0);
        w_state_next    = ITER;
      end
      ITER: begin
        w_a_next = w_step_a;
        w_q_next = w_step_q;
        if (r_count == '0) begin
          w_quotient_next  = w_step_q;
          w_remainder_next = w_step_a[WIDTH-1:0];
          w_dbz_next       = r_dbz_pend;
          w_state_next     = DONE;
        end else begin
          w_count_next = r_count - CW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_dbz_pend  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_a         <= w_a_next;
      r_q         <= w_q_next;
      r_count     <= w_count_next;
      r_quotient  <= w_quotient_next;
      r_remainder <= w_remainder_next;
      r_dbz       <= w_dbz_next;
      r_dbz_pend  <= w_dbz_pend_next;
    end
  end

endmodule
